// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host byte receiver with parity/stop/timeout checks and a FWFT byte FIFO.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int TIMEOUT_CYCLES  = 50000,
  parameter bit CHECK_PARITY    = 1'b1,
  parameter bit DROP_ON_ERROR   = 1'b1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     PS2_CLK,
  input  logic                     PS2_DAT,
  input  logic                     rd_en,
  input  logic                     clear_errors,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     rx_busy,
  output logic                     parity_error,
  output logic                     frame_error,
  output logic                     overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMR_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_COMMIT} state_t;

  // Lines idle high, so synchroniser flops reset to 1 to avoid a spurious fall.
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, fall;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = ~clk_s & clk_prev_q;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            par_ok, wr_en, par_err_ev, frame_err_ev;

  assign par_ok = !CHECK_PARITY || (^{shreg_q, par_q});

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    timer_d      = '0;
    wr_en        = 1'b0;
    par_err_ev   = 1'b0;
    frame_err_ev = 1'b0;
    if (state_q != S_IDLE && !fall) timer_d = timer_q + TMR_ONE;
    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_d   = {dat_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (!dat_s) begin
            frame_err_ev = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        state_d    = S_IDLE;
        par_err_ev = !par_ok;
        wr_en      = par_ok || !DROP_ON_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    // A stalled device aborts the frame; a fall in the same cycle keeps it alive.
    if (state_q != S_IDLE && state_q != S_COMMIT && !fall && timer_q == TMR_END) begin
      state_d      = S_IDLE;
      frame_err_ev = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'h00;
      par_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      timer_q   <= timer_d;
    end
  end

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rd_fire, wr_fire, full, ovf_ev;
  logic          perr_q, ferr_q, ovf_q;

  assign full    = (count_q == CW'(DEPTH));
  assign rd_fire = rd_en && (count_q != '0);
  assign wr_fire = wr_en && (!full || rd_fire);
  assign ovf_ev  = wr_en && full && !rd_fire;

  always_comb begin
    count_d = count_q;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_fire) mem_q[wr_ptr_q] <= shreg_q;
  end

  // Error events take precedence over a coincident clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      perr_q  <= (perr_q & ~clear_errors) | par_err_ev;
      ferr_q  <= (ferr_q & ~clear_errors) | frame_err_ev;
      ovf_q   <= (ovf_q & ~clear_errors) | ovf_ev;
    end
  end

  assign rd_valid     = (count_q != '0);
  assign rd_data      = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count   = count_q;
  assign rx_busy      = (state_q != S_IDLE);
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized bench for ps2_rx_fifo against a frame-level queue model.
module tb_ps2_rx_fifo;

  localparam int LOG2 = 4;
  localparam int DEPTH = 16;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1, reset_b = 1'b1;
  logic ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic rd_en = 1'b0, clear_errors = 1'b0;
  logic rd_en_b = 1'b0, clear_b = 1'b0;

  logic [7:0]    rd_data, rd_data_b;
  logic          rd_valid, rd_valid_b, rx_busy, rx_busy_b;
  logic [LOG2:0] fifo_count, fifo_count_b;
  logic          parity_error, frame_error, overflow;
  logic          parity_error_b, frame_error_b, overflow_b;

  ps2_rx_fifo #(.FIFO_DEPTH_LOG2(LOG2), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b1),
                .DROP_ON_ERROR(1'b1), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .rd_en(rd_en), .clear_errors(clear_errors), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .rx_busy(rx_busy), .parity_error(parity_error),
    .frame_error(frame_error), .overflow(overflow));

  ps2_rx_fifo #(.FIFO_DEPTH_LOG2(LOG2), .TIMEOUT_CYCLES(200), .CHECK_PARITY(1'b1),
                .DROP_ON_ERROR(1'b0), .SYNC_STAGES(2)) dut_keep (
    .CLOCK_50(CLOCK_50), .reset(reset_b), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .rd_en(rd_en_b), .clear_errors(clear_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .fifo_count(fifo_count_b), .rx_busy(rx_busy_b), .parity_error(parity_error_b),
    .frame_error(frame_error_b), .overflow(overflow_b));

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  logic [7:0] q_m[$];
  logic perr_m = 1'b0, ferr_m = 1'b0, ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One PS/2 bit: 40 system cycles, falling edge in the middle of the data window.
  task automatic ps2_bit(input logic b, input logic rd_at_commit);
    ps2_dat = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    if (rd_at_commit) begin
      wait_cyc(3);
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
      wait_cyc(16);
    end else begin
      wait_cyc(20);
    end
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic rd_at_commit);
    logic ok;
    if (rd_at_commit && q_m.size() > 0) void'(q_m.pop_front());
    if (!stop) begin
      ferr_m = 1'b1;
    end else begin
      ok = ((^d) ^ par) == 1'b1;
      if (!ok) perr_m = 1'b1;
      else if (q_m.size() == DEPTH) ovf_m = 1'b1;
      else q_m.push_back(d);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic rd_at_commit);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stop, rd_at_commit);
    model_frame(d, par, stop, rd_at_commit);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, ~^d, 1'b1, 1'b0);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(fifo_count), 32'(q_m.size()));
    check({tag, ".valid"}, 32'(rd_valid), 32'(q_m.size() > 0));
    if (q_m.size() > 0) check({tag, ".data"}, 32'(rd_data), 32'(q_m[0]));
    check({tag, ".perr"}, 32'(parity_error), 32'(perr_m));
    check({tag, ".ferr"}, 32'(frame_error), 32'(ferr_m));
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
  endtask

  task automatic do_read(input string tag);
    if (q_m.size() > 0) check({tag, ".rdata"}, 32'(rd_data), 32'(q_m[0]));
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
    if (q_m.size() > 0) void'(q_m.pop_front());
  endtask

  task automatic do_clear();
    clear_errors = 1'b1;
    wait_cyc(1);
    clear_errors = 1'b0;
    perr_m = 1'b0;
    ferr_m = 1'b0;
    ovf_m  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rd_data"}, 32'(rd_data), 32'h0);
    check({tag, ".valid"}, 32'(rd_valid), 32'h0);
    check({tag, ".count"}, 32'(fifo_count), 32'h0);
    check({tag, ".busy"}, 32'(rx_busy), 32'h0);
    check({tag, ".flags"}, 32'({parity_error, frame_error, overflow}), 32'h0);
  endtask

  initial begin
    logic [7:0] d;
    logic       par, stop;
    int         nrd;

    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    check_all_zero("reset");

    // T1: good byte, then pop
    send_good(8'h1C);
    check_state("t1");
    do_read("t1");
    check("t1.empty", 32'(rd_valid), 32'h0);

    // T2: parity error dropped; the keep instance stores it with the flag set
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check_state("t2");
    check("t2.perr_set", 32'(parity_error), 32'h1);
    do_clear();
    reset_b = 1'b0;
    wait_cyc(2);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("t2b.data", 32'(rd_data_b), 32'hF0);
    check("t2b.valid", 32'(rd_valid_b), 32'h1);
    check("t2b.count", 32'(fifo_count_b), 32'h1);
    check("t2b.perr", 32'(parity_error_b), 32'h1);
    reset_b = 1'b1;
    check_state("t2.again");
    do_clear();

    // T3a: bad stop bit
    send_frame(8'h29, ~^8'h29, 1'b0, 1'b0);
    check_state("t3a");
    do_clear();

    // T3b: clock stalls after 4 data bits
    ps2_bit(1'b0, 1'b0);
    check("t3b.busy_mid", 32'(rx_busy), 32'h1);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(250);
    ferr_m = 1'b1;
    check("t3b.busy", 32'(rx_busy), 32'h0);
    check_state("t3b");
    do_clear();
    send_good(8'h29);
    check_state("t3b.after");
    while (q_m.size() > 0) do_read("t3b.drain");

    // T4: 17 frames without reads
    for (int i = 0; i <= 16; i++) send_good(8'(i));
    check("t4.count", 32'(fifo_count), 32'd16);
    check("t4.ovf", 32'(overflow), 32'h1);
    check_state("t4");
    for (int i = 0; i < 16; i++) do_read("t4");
    check("t4.count_end", 32'(fifo_count), 32'd0);
    do_clear();

    // T5: simultaneous read and write while full
    for (int i = 0; i < 16; i++) send_good(8'($urandom_range(0, 255)));
    send_frame(8'h55, ~^8'h55, 1'b1, 1'b1);
    check("t5.count", 32'(fifo_count), 32'd16);
    check("t5.ovf", 32'(overflow), 32'h0);
    check("t5.last", 32'(q_m[DEPTH-1]), 32'h55);
    check_state("t5");
    while (q_m.size() > 0) do_read("t5.drain");

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      d    = 8'($urandom_range(0, 255));
      par  = ($urandom_range(0, 4) == 0) ? (^d) : ~^d;
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, par, stop, 1'b0);
      check_state("rand.frame");
      nrd = $urandom_range(0, 3);
      for (int r = 0; r < nrd; r++) if (q_m.size() > 0) do_read("rand");
      if ($urandom_range(0, 3) == 0) do_clear();
      check_state("rand.post");
    end

    // T6: reset mid-frame
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    q_m.delete();
    perr_m = 1'b0;
    ferr_m = 1'b0;
    ovf_m  = 1'b0;
    check_all_zero("t6");
    ps2_dat = 1'b1;
    wait_cyc(5);
    send_good(8'h1C);
    check_state("t6.after");
    check("t6.data", 32'(rd_data), 32'h1C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
